// File: rtl/two_stream_merge_pkg.sv
// two_stream_merge_pkg
// Shared types and constants for the two-stream round-robin merge.
//   ptr_t : round-robin pointer, P_FIRST favours source 0, P_SECOND favours source 1
//   src_t : source index carried alongside each output beat
//   N_SRC : number of merged sources
package two_stream_merge_pkg;

    localparam int unsigned N_SRC = 2;

    typedef enum logic {
        P_FIRST  = 1'b0,
        P_SECOND = 1'b1
    } ptr_t;

    typedef logic src_t;

endpackage

// File: rtl/two_stream_merge_rr_if.sv
// two_stream_merge_rr_if
// Handshake bundle between two producers, the merge block and one consumer.
//   up_valid[1:0], up_data_0, up_data_1, up_last[1:0] : producer side, into the merge
//   up_ready[1:0]                                      : per-source ready, out of the merge
//   down_valid, down_data, down_src                    : merged stream, out of the merge
//   down_ready                                         : consumer ready, into the merge
// Modports: slave = merge block view, master = surrounding environment view.
interface two_stream_merge_rr_if #(
    parameter int unsigned DATA_W = 8
);
    import two_stream_merge_pkg::*;

    logic [N_SRC-1:0]  up_valid;
    logic [DATA_W-1:0] up_data_0;
    logic [DATA_W-1:0] up_data_1;
    logic [N_SRC-1:0]  up_last;
    logic [N_SRC-1:0]  up_ready;
    logic              down_valid;
    logic [DATA_W-1:0] down_data;
    src_t              down_src;
    logic              down_ready;

    modport slave (
        input  up_valid, up_data_0, up_data_1, up_last, down_ready,
        output up_ready, down_valid, down_data, down_src
    );

    modport master (
        output up_valid, up_data_0, up_data_1, up_last, down_ready,
        input  up_ready, down_valid, down_data, down_src
    );

endinterface

// File: rtl/two_stream_merge_out_reg.sv
// two_stream_merge_out_reg
// Single-entry output register for the merged stream, plus its load equation.
//   clk, rst    : clock, synchronous active-high reset
//   take        : a source transfers this cycle (only ever asserted while load=1)
//   in_data     : beat of the transferring source
//   in_src      : index of the transferring source
//   down_ready  : consumer ready
//   load        : register can accept a beat this cycle (empty or being drained)
//   down_valid, down_data, down_src : registered output beat
module two_stream_merge_out_reg
    import two_stream_merge_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              take,
    input  logic [DATA_W-1:0] in_data,
    input  src_t              in_src,
    input  logic              down_ready,
    output logic              load,
    output logic              down_valid,
    output logic [DATA_W-1:0] down_data,
    output src_t              down_src
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    src_t              src_q;

    always_comb begin
        load = !valid_q || down_ready;
    end

    // Draining and refilling in the same cycle overwrites the old beat, so no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= src_t'(1'b0);
        end else if (load) begin
            valid_q <= take;
            if (take) begin
                data_q <= in_data;
                src_q  <= in_src;
            end
        end
    end

    assign down_valid = valid_q;
    assign down_data  = data_q;
    assign down_src   = src_q;

endmodule

// File: rtl/two_stream_merge_rr.sv
// two_stream_merge_rr
// Merges two valid/ready streams into one registered stream with round-robin
// arbitration. The pointer moves only on an accepted transfer, so back-pressure
// never skews fairness.
//   clk, rst : clock, synchronous active-high reset
//   bus      : two_stream_merge_rr_if.slave (up_* producer side, down_* consumer side)
// Optional feature: define TWO_STREAM_MERGE_BURST_LOCK_EN to hold the grant on a
// source until it sends a beat with up_last set. Without it up_last is ignored.
module two_stream_merge_rr
    import two_stream_merge_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    two_stream_merge_rr_if.slave bus
);

    ptr_t              ptr_q, ptr_d;
    logic              load;
    logic [N_SRC-1:0]  grant;
    logic [N_SRC-1:0]  xfer;
    src_t              xfer_src;
    logic [DATA_W-1:0] xfer_data;

`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
    logic locked_q, locked_d;
    src_t lock_src_q, lock_src_d;
`else
    logic unused_last;
    assign unused_last = ^bus.up_last;
`endif

    always_comb begin
        grant[0] = bus.up_valid[0] && (!bus.up_valid[1] || ptr_q == P_FIRST);
        grant[1] = bus.up_valid[1] && (!bus.up_valid[0] || ptr_q == P_SECOND);
`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
        // Mid-burst, only the locked source may be granted.
        if (locked_q) begin
            grant             = '0;
            grant[lock_src_q] = bus.up_valid[lock_src_q];
        end
`endif
    end

    // Ready is combinational from grant and load; forced low while in reset.
    always_comb begin
        bus.up_ready = rst ? '0 : (grant & {N_SRC{load}});
        xfer         = bus.up_valid & bus.up_ready;
        xfer_src     = src_t'(xfer[1]);
        xfer_data    = xfer[1] ? bus.up_data_1 : bus.up_data_0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|xfer) begin
            ptr_d = xfer[0] ? P_SECOND : P_FIRST;
        end
    end

`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
    always_comb begin
        locked_d   = locked_q;
        lock_src_d = lock_src_q;
        if (|xfer) begin
            locked_d   = !bus.up_last[xfer_src];
            lock_src_d = xfer_src;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= P_FIRST;
`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
            locked_q   <= 1'b0;
            lock_src_q <= src_t'(1'b0);
`endif
        end else begin
            ptr_q <= ptr_d;
`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
            locked_q   <= locked_d;
            lock_src_q <= lock_src_d;
`endif
        end
    end

    two_stream_merge_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .take       (|xfer),
        .in_data    (xfer_data),
        .in_src     (xfer_src),
        .down_ready (bus.down_ready),
        .load       (load),
        .down_valid (bus.down_valid),
        .down_data  (bus.down_data),
        .down_src   (bus.down_src)
    );

endmodule

// File: tb/tb_two_stream_merge_rr.sv
// tb_two_stream_merge_rr
// Self-checking bench for two_stream_merge_rr: directed vector table, burst
// sequence (lock-aware when TWO_STREAM_MERGE_BURST_LOCK_EN is defined) and a
// randomized run against a behavioural model with a beat scoreboard.
module tb_two_stream_merge_rr;
    import two_stream_merge_pkg::*;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    two_stream_merge_rr_if #(.DATA_W(DW)) bus ();

    two_stream_merge_rr #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [1:0] last, input logic rdy);
        rst            = r;
        bus.up_valid   = v;
        bus.up_data_0  = d0;
        bus.up_data_1  = d1;
        bus.up_last    = last;
        bus.down_ready = rdy;
    endtask

    typedef struct {
        logic       r;
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rdy;
        logic [1:0] exp_rdy;
        logic       exp_dv;
        logic       exp_src;
        logic [7:0] exp_data;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] v, logic [7:0] d0, logic [7:0] d1,
                                logic rdy, logic [1:0] er, logic edv, logic es,
                                logic [7:0] ed);
        vec_t t;
        t.r = r; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.exp_rdy = er; t.exp_dv = edv; t.exp_src = es; t.exp_data = ed;
        return t;
    endfunction

    vec_t vecs[$];

    // Behavioural reference state for the random run.
    int         prefer;
    int         lock_on;
    int         lock_src;
    logic       m_dv;
    logic       m_src;
    logic [7:0] m_data;
    logic [8:0] sb[$];

    initial begin
        // reset, then alternating single source
        vecs.push_back(mk(1, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 2'b01, 8'h11, 8'h00, 1, 2'b01, 1, 0, 8'h11));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 2'b10, 8'h00, 8'h22, 1, 2'b10, 1, 1, 8'h22));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00));
        // both valid, full throughput, alternating
        vecs.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 1, 2'b01, 1, 0, 8'hA0));
        vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 1, 2'b10, 1, 1, 8'hB0));
        vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB1, 1, 2'b01, 1, 0, 8'hA1));
        vecs.push_back(mk(0, 2'b11, 8'hA2, 8'hB1, 1, 2'b10, 1, 1, 8'hB1));
        // back-pressure for three cycles after the first beat
        vecs.push_back(mk(0, 2'b11, 8'hA0, 8'hB0, 1, 2'b01, 1, 0, 8'hA0));
        vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 0, 2'b00, 1, 0, 8'hA0));
        vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 0, 2'b00, 1, 0, 8'hA0));
        vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 0, 2'b00, 1, 0, 8'hA0));
        vecs.push_back(mk(0, 2'b11, 8'hA1, 8'hB0, 1, 2'b10, 1, 1, 8'hB0));
        // reset while a beat is held and both sources request
        vecs.push_back(mk(1, 2'b11, 8'hA1, 8'hB0, 0, 2'b00, 0, 0, 8'h00));
        vecs.push_back(mk(0, 2'b11, 8'hC0, 8'hD0, 1, 2'b01, 1, 0, 8'hC0));
        vecs.push_back(mk(0, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 0, 8'h00));

        drive(1, 2'b00, 8'h00, 8'h00, 2'b11, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].d0, vecs[i].d1, 2'b11, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_up_ready", i), 32'(bus.up_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_down_valid", i), 32'(bus.down_valid), 32'(vecs[i].exp_dv));
            if (vecs[i].exp_dv) begin
                chk($sformatf("vec%0d_down_src", i), 32'(bus.down_src), 32'(vecs[i].exp_src));
                chk($sformatf("vec%0d_down_data", i), 32'(bus.down_data),
                    32'(vecs[i].exp_data));
            end
        end

        // Burst: source 0 sends three beats (last on the third), source 1 always valid.
        begin
            logic exp_src_seq [4];
            int   n0;
            int   n1;
            logic [1:0] rdy_seen;
`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
            exp_src_seq[0] = 0; exp_src_seq[1] = 0; exp_src_seq[2] = 0; exp_src_seq[3] = 1;
`else
            exp_src_seq[0] = 0; exp_src_seq[1] = 1; exp_src_seq[2] = 0; exp_src_seq[3] = 1;
`endif
            drive(1, 2'b00, 8'h00, 8'h00, 2'b11, 1);
            @(posedge clk);
            #1;
            n0 = 0;
            n1 = 0;
            for (int k = 0; k < 4; k++) begin
                drive(0, 2'b11, 8'(8'h50 + n0), 8'(8'h60 + n1), {1'b1, n0 == 2}, 1);
                #1;
                rdy_seen = bus.up_ready;
                @(posedge clk);
                #1;
                chk($sformatf("burst%0d_down_valid", k), 32'(bus.down_valid), 32'd1);
                chk($sformatf("burst%0d_down_src", k), 32'(bus.down_src),
                    32'(exp_src_seq[k]));
                if (rdy_seen[0]) n0++;
                if (rdy_seen[1]) n1++;
            end
        end

        // Randomized run against the reference model.
        drive(1, 2'b00, 8'h00, 8'h00, 2'b11, 1);
        @(posedge clk);
        #1;
        prefer = 0; lock_on = 0; lock_src = 0;
        m_dv = 0; m_src = 0; m_data = 0;
        sb.delete();
        for (int c = 0; c < 3000; c++) begin
            logic       r;
            logic [1:0] v;
            logic [1:0] last;
            logic [7:0] d0;
            logic [7:0] d1;
            logic       rdy;
            logic       load;
            logic [1:0] cands;
            int         win;
            logic [1:0] exp_rdy;
            logic [8:0] beat;

            r    = ($urandom_range(0, 99) == 0);
            v    = 2'($urandom);
            last = 2'($urandom);
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            drive(r, v, d0, d1, last, rdy);
            #1;

            load  = !m_dv || rdy;
            cands = v;
            if (lock_on != 0) cands = v & (2'b01 << lock_src);
            if (cands == 2'b11)      win = prefer;
            else if (cands == 2'b01) win = 0;
            else if (cands == 2'b10) win = 1;
            else                     win = -1;
            exp_rdy = (!r && load && win >= 0) ? (2'b01 << win) : 2'b00;
            chk("rand_up_ready", 32'(bus.up_ready), 32'(exp_rdy));

            // Scoreboard: every consumed beat must be the oldest accepted one.
            if (!r && bus.down_valid && rdy) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    beat = sb.pop_front();
                    chk("sb_beat", 32'({bus.down_src, bus.down_data}), 32'(beat));
                end
            end

            @(posedge clk);
            if (r) begin
                m_dv = 0; m_src = 0; m_data = 0;
                prefer = 0; lock_on = 0; lock_src = 0;
                sb.delete();
            end else if (load && win >= 0) begin
                m_dv   = 1;
                m_src  = (win == 1);
                m_data = (win == 1) ? d1 : d0;
                prefer = 1 - win;
`ifdef TWO_STREAM_MERGE_BURST_LOCK_EN
                lock_on  = last[win] ? 0 : 1;
                lock_src = win;
`endif
                sb.push_back({m_src, m_data});
            end else if (load) begin
                m_dv = 0;
            end
            #1;
            chk("rand_down_valid", 32'(bus.down_valid), 32'(m_dv));
            if (m_dv) begin
                chk("rand_down_src", 32'(bus.down_src), 32'(m_src));
                chk("rand_down_data", 32'(bus.down_data), 32'(m_data));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
